// File: rtl/control_step_sequencer_pkg.sv
// Shared opcodes, state/class enums and IR field helpers
// for the hardwired control-step sequencer.
package cpu_ctrl_pkg;

  localparam int IR_MAX_W    = 64;
  localparam int FIELD_MAX_W = 8;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T1W, S_T2,
    S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    CL_BINARY, CL_UNARY, CL_MULDIV,
    CL_NOP, CL_HALT, CL_ILLEGAL
  } op_class_e;

  function automatic op_class_e op_class(
    input logic [4:0] op
  );
    op_class_e c;
    unique case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL:
        c = CL_BINARY;
      OP_NEG, OP_NOT: c = CL_UNARY;
      OP_MUL, OP_DIV: c = CL_MULDIV;
      OP_NOP:         c = CL_NOP;
      OP_HALT:        c = CL_HALT;
      default:        c = CL_ILLEGAL;
    endcase
    return c;
  endfunction

  function automatic logic [4:0] ir_opcode(
    input logic [IR_MAX_W-1:0] ir,
    input int                  irw
  );
    logic [IR_MAX_W-1:0] sh;
    sh = ir >> (irw - 5);
    return sh[4:0];
  endfunction

  // idx 0 = Ra, 1 = Rb, 2 = Rc, packed downward below the opcode
  function automatic logic [FIELD_MAX_W-1:0] ir_field(
    input logic [IR_MAX_W-1:0] ir,
    input int                  irw,
    input int                  rfw,
    input int                  idx
  );
    logic [IR_MAX_W-1:0] sh;
    logic [IR_MAX_W-1:0] m;
    sh = ir >> (irw - 5 - (idx + 1) * rfw);
    m  = (IR_MAX_W'(1) << rfw) - IR_MAX_W'(1);
    sh = sh & m;
    return sh[FIELD_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/control_step_sequencer_if.sv
// Control bundle between the step sequencer (master)
// and the bus datapath (slave).
interface control_step_sequencer_if #(
  parameter int REG_FIELD_W = 4,
  parameter int IR_WIDTH    = 32
);
  localparam int NUM_REGS = 2 ** REG_FIELD_W;

  logic                run;
  logic [IR_WIDTH-1:0] ir;
  logic                mem_ready;
  logic [NUM_REGS-1:0] Rin;
  logic [NUM_REGS-1:0] Rout;
  logic PCout, PCin, MARin, IncPC;
  logic Read, MDRin, MDRout, IRin;
  logic Yin, Zin, Zlowout, Zhighout;
  logic HIin, LOin;
  logic [4:0]          opcode;
  logic                instr_done;
  logic                halted;
  logic                illegal;

  modport master (
    input  run, ir, mem_ready,
    output Rin, Rout,
    output PCout, PCin, MARin, IncPC,
    output Read, MDRin, MDRout, IRin,
    output Yin, Zin, Zlowout, Zhighout,
    output HIin, LOin,
    output opcode, instr_done, halted, illegal
  );

  modport slave (
    output run, ir, mem_ready,
    input  Rin, Rout,
    input  PCout, PCin, MARin, IncPC,
    input  Read, MDRin, MDRout, IRin,
    input  Yin, Zin, Zlowout, Zhighout,
    input  HIin, LOin,
    input  opcode, instr_done, halted, illegal
  );
endinterface

// File: rtl/control_step_sequencer_reg_select_decoder.sv
// Index + enable to one-hot register strobe decoder.
module reg_select_decoder #(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0]      idx_i,
  input  logic                  en_i,
  output logic [2**IDX_W-1:0]   onehot_o
);
  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end
endmodule

// File: rtl/control_step_sequencer.sv
// Hardwired T-state control unit for the bus CPU datapath.
// Define CTRL_MULDIV_EN to enable the MUL/DIV HI/LO sequence.
module control_step_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_FIELD_W = 4,
  parameter int IR_WIDTH    = 32
) (
  input logic                      Clock,
  input logic                      clear,
  control_step_sequencer_if.master bus
);

  state_e    state_q, state_d, done_next;
  op_class_e cls_raw, cls;

  logic [IR_MAX_W-1:0]    ir_x;
  logic [4:0]             op;
  logic [REG_FIELD_W-1:0] ra, rb, rc;
  logic [REG_FIELD_W-1:0] rin_idx, rout_idx;
  logic                   rin_en, rout_en;

  assign ir_x = IR_MAX_W'(bus.ir);
  assign op   = ir_opcode(ir_x, IR_WIDTH);
  assign ra   = REG_FIELD_W'(
    ir_field(ir_x, IR_WIDTH, REG_FIELD_W, 0));
  assign rb   = REG_FIELD_W'(
    ir_field(ir_x, IR_WIDTH, REG_FIELD_W, 1));
  assign rc   = REG_FIELD_W'(
    ir_field(ir_x, IR_WIDTH, REG_FIELD_W, 2));

  assign cls_raw = op_class(op);
`ifdef CTRL_MULDIV_EN
  assign cls = cls_raw;
`else
  assign cls = (cls_raw == CL_MULDIV) ?
               CL_ILLEGAL : cls_raw;
`endif

  assign done_next = bus.run ? S_T0 : S_IDLE;

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = bus.mem_ready ? S_T2 : S_T1W;
      S_T1W:  if (bus.mem_ready) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        unique case (cls)
          CL_BINARY, CL_MULDIV: state_d = S_T4;
          CL_UNARY:             state_d = S_T5;
          CL_HALT:              state_d = S_HALT;
          default:              state_d = done_next;
        endcase
      end
      S_T4: state_d = S_T5;
      S_T5: begin
`ifdef CTRL_MULDIV_EN
        state_d = (cls == CL_MULDIV) ? S_T6 : done_next;
`else
        state_d = done_next;
`endif
      end
`ifdef CTRL_MULDIV_EN
      S_T6:   state_d = done_next;
`endif
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore decode; ir is only consulted from T3 on
  always_comb begin
    rin_en = 1'b0;  rin_idx = '0;
    rout_en = 1'b0; rout_idx = '0;
    bus.PCout = 1'b0;   bus.PCin = 1'b0;
    bus.MARin = 1'b0;   bus.IncPC = 1'b0;
    bus.Read = 1'b0;    bus.MDRin = 1'b0;
    bus.MDRout = 1'b0;  bus.IRin = 1'b0;
    bus.Yin = 1'b0;     bus.Zin = 1'b0;
    bus.Zlowout = 1'b0; bus.opcode = 5'd0;
    bus.instr_done = 1'b0;
    bus.halted = 1'b0;  bus.illegal = 1'b0;
`ifdef CTRL_MULDIV_EN
    bus.Zhighout = 1'b0;
    bus.HIin = 1'b0;    bus.LOin = 1'b0;
`endif
    unique case (state_q)
      S_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1;
        bus.IncPC = 1'b1; bus.Zin = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1; bus.PCin = 1'b1;
        bus.Read = 1'b1;    bus.MDRin = 1'b1;
      end
      S_T1W: begin
        bus.Read = 1'b1; bus.MDRin = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      S_T3: begin
        unique case (1'b1)
          (cls == CL_BINARY),
          (cls == CL_MULDIV): begin
            rout_en = 1'b1; rout_idx = rb;
            bus.Yin = 1'b1;
          end
          (cls == CL_UNARY): begin
            rout_en = 1'b1; rout_idx = rb;
            bus.Zin = 1'b1; bus.opcode = op;
          end
          (cls == CL_NOP),
          (cls == CL_HALT): bus.instr_done = 1'b1;
          default: begin
            bus.illegal = 1'b1;
            bus.instr_done = 1'b1;
          end
        endcase
      end
      S_T4: begin
        rout_en = 1'b1; rout_idx = rc;
        bus.Zin = 1'b1; bus.opcode = op;
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        if (cls == CL_MULDIV) begin
`ifdef CTRL_MULDIV_EN
          bus.LOin = 1'b1;
`endif
        end else begin
          rin_en = 1'b1; rin_idx = ra;
          bus.instr_done = 1'b1;
        end
      end
`ifdef CTRL_MULDIV_EN
      S_T6: begin
        bus.Zhighout = 1'b1; bus.HIin = 1'b1;
        bus.instr_done = 1'b1;
      end
`endif
      S_HALT: bus.halted = 1'b1;
      default: ;
    endcase
  end

`ifndef CTRL_MULDIV_EN
  assign bus.Zhighout = 1'b0;
  assign bus.HIin     = 1'b0;
  assign bus.LOin     = 1'b0;
`endif

  reg_select_decoder #(.IDX_W(REG_FIELD_W)) u_rin (
    .idx_i    (rin_idx),
    .en_i     (rin_en),
    .onehot_o (bus.Rin)
  );

  reg_select_decoder #(.IDX_W(REG_FIELD_W)) u_rout (
    .idx_i    (rout_idx),
    .en_i     (rout_en),
    .onehot_o (bus.Rout)
  );

endmodule

// File: tb/tb_control_step_sequencer.sv
// Randomised bench for control_step_sequencer against a
// per-cycle strobe-sequence reference model.
module tb_control_step_sequencer;

  localparam int RFW = 4;
  localparam int IRW = 32;

  localparam logic [13:0] PCOUT  = 14'h0001;
  localparam logic [13:0] PCIN   = 14'h0002;
  localparam logic [13:0] MARIN  = 14'h0004;
  localparam logic [13:0] INCPC  = 14'h0008;
  localparam logic [13:0] READ   = 14'h0010;
  localparam logic [13:0] MDRIN  = 14'h0020;
  localparam logic [13:0] MDROUT = 14'h0040;
  localparam logic [13:0] IRIN   = 14'h0080;
  localparam logic [13:0] YIN    = 14'h0100;
  localparam logic [13:0] ZIN    = 14'h0200;
  localparam logic [13:0] ZLO    = 14'h0400;
  localparam logic [13:0] ZHI    = 14'h0800;
  localparam logic [13:0] HIIN   = 14'h1000;
  localparam logic [13:0] LOIN   = 14'h2000;

  typedef struct packed {
    logic [13:0] strb;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  opc;
    logic        done;
    logic        halted;
    logic        ill;
  } vec_t;

  logic Clock = 1'b0;
  logic clear;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t exp_q[$];
  vec_t got_q[$];

  control_step_sequencer_if #(
    .REG_FIELD_W(RFW), .IR_WIDTH(IRW)) ctl ();

  control_step_sequencer #(
    .REG_FIELD_W(RFW), .IR_WIDTH(IRW)
  ) dut (
    .Clock (Clock),
    .clear (clear),
    .bus   (ctl)
  );

  always #5 Clock = ~Clock;

  function automatic vec_t observe();
    vec_t o;
    o.strb = {ctl.LOin, ctl.HIin, ctl.Zhighout,
              ctl.Zlowout, ctl.Zin, ctl.Yin,
              ctl.IRin, ctl.MDRout, ctl.MDRin,
              ctl.Read, ctl.IncPC, ctl.MARin,
              ctl.PCin, ctl.PCout};
    o.rin    = ctl.Rin;
    o.rout   = ctl.Rout;
    o.opc    = ctl.opcode;
    o.done   = ctl.instr_done;
    o.halted = ctl.halted;
    o.ill    = ctl.illegal;
    return o;
  endfunction

  function automatic vec_t v(
    input logic [13:0] s, input logic [15:0] ri,
    input logic [15:0] ro, input logic [4:0] op,
    input logic d, input logic il);
    vec_t o;
    o.strb = s; o.rin = ri; o.rout = ro;
    o.opc = op; o.done = d; o.halted = 1'b0;
    o.ill = il;
    return o;
  endfunction

  function automatic logic [15:0] oh(input logic [3:0] i);
    return 16'(1) << i;
  endfunction

  // 0 binary, 1 unary, 2 mul/div, 3 nop, 4 halt, 5 illegal
  function automatic int kind(input logic [4:0] op);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6,
      5'd7, 5'd8, 5'd9, 5'd10: return 0;
      5'd16, 5'd17:            return 1;
`ifdef CTRL_MULDIV_EN
      5'd14, 5'd15:            return 2;
`endif
      5'd26:                   return 3;
      5'd27:                   return 4;
      default:                 return 5;
    endcase
  endfunction

  function automatic logic [31:0] instr(
    input logic [4:0] op, input logic [3:0] ra,
    input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'($urandom)};
  endfunction

  task automatic model(input logic [31:0] ir,
                       input int nwait);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    op = ir[31:27]; ra = ir[26:23];
    rb = ir[22:19]; rc = ir[18:15];
    exp_q.delete();
    exp_q.push_back(v(PCOUT|MARIN|INCPC|ZIN,
                      0, 0, 0, 0, 0));
    exp_q.push_back(v(ZLO|PCIN|READ|MDRIN,
                      0, 0, 0, 0, 0));
    repeat (nwait)
      exp_q.push_back(v(READ|MDRIN, 0, 0, 0, 0, 0));
    exp_q.push_back(v(MDROUT|IRIN, 0, 0, 0, 0, 0));
    case (kind(op))
      0: begin
        exp_q.push_back(v(YIN, 0, oh(rb), 0, 0, 0));
        exp_q.push_back(v(ZIN, 0, oh(rc), op, 0, 0));
        exp_q.push_back(v(ZLO, oh(ra), 0, 0, 1, 0));
      end
      1: begin
        exp_q.push_back(v(ZIN, 0, oh(rb), op, 0, 0));
        exp_q.push_back(v(ZLO, oh(ra), 0, 0, 1, 0));
      end
      2: begin
        exp_q.push_back(v(YIN, 0, oh(rb), 0, 0, 0));
        exp_q.push_back(v(ZIN, 0, oh(rc), op, 0, 0));
        exp_q.push_back(v(ZLO|LOIN, 0, 0, 0, 0, 0));
        exp_q.push_back(v(ZHI|HIIN, 0, 0, 0, 1, 0));
      end
      3, 4: exp_q.push_back(v(0, 0, 0, 0, 1, 0));
      default: exp_q.push_back(v(0, 0, 0, 0, 1, 1));
    endcase
  endtask

  // Entered just after the edge that puts the DUT in T0
  task automatic drive(input logic [31:0] ir,
                       input int nwait,
                       input bit run_after);
    model(ir, nwait);
    got_q.delete();
    ctl.ir = ir;
    foreach (exp_q[k]) begin
      if (k >= 1 && k <= nwait + 1)
        ctl.mem_ready = (k > nwait);
      else
        ctl.mem_ready = 1'($urandom);
      ctl.run = (k == exp_q.size() - 1) ?
                run_after : 1'($urandom);
      @(negedge Clock);
      got_q.push_back(observe());
      @(posedge Clock); #1;
    end
  endtask

  task automatic start();
    ctl.run = 1'b1;
    @(posedge Clock); #1;
  endtask

  task automatic test_reset();
    clear = 1'b1; ctl.run = 1'b0;
    ctl.mem_ready = 1'b0; ctl.ir = '0;
    #1;
    n_vec++;
    if (observe() !== '0) begin
      n_err++;
      $display("FAIL reset_async got=%h want=0",
               observe());
    end
    @(posedge Clock); #1;
    clear = 1'b0;
    repeat (3) begin
      ctl.mem_ready = 1'($urandom);
      @(negedge Clock);
      n_vec++;
      if (observe() !== '0) begin
        n_err++;
        $display("FAIL reset_idle got=%h want=0",
                 observe());
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_and();
    int d;
    start();
    drive(32'h28918000, 0, 1'b0);
    foreach (exp_q[k]) begin
      n_vec++;
      if (got_q[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL and cyc%0d got=%h want=%h",
                 k, got_q[k], exp_q[k]);
      end
    end
    d = -1;
    foreach (got_q[k]) if (got_q[k].done && d < 0) d = k;
    n_vec++;
    if (d !== 5) begin
      n_err++;
      $display("FAIL and_latency got=%0d want=5", d);
    end
  endtask

  task automatic test_wait();
    int pc;
    int d;
    start();
    drive(32'h28918000, 3, 1'b0);
    foreach (exp_q[k]) begin
      n_vec++;
      if (got_q[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL wait cyc%0d got=%h want=%h",
                 k, got_q[k], exp_q[k]);
      end
    end
    pc = 0; d = -1;
    foreach (got_q[k]) begin
      if (got_q[k].strb[1]) pc++;
      if (got_q[k].done && d < 0) d = k;
    end
    n_vec++;
    if (pc !== 1 || d !== 8) begin
      n_err++;
      $display("FAIL wait_pcin got=%0d/%0d want=1/8",
               pc, d);
    end
  endtask

  task automatic test_neg();
    int d;
    start();
    drive({5'b10000, 4'd4, 4'd5, 4'd0, 15'd0},
          0, 1'b0);
    foreach (exp_q[k]) begin
      n_vec++;
      if (got_q[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL neg cyc%0d got=%h want=%h",
                 k, got_q[k], exp_q[k]);
      end
    end
    d = -1;
    foreach (got_q[k]) if (got_q[k].done && d < 0) d = k;
    n_vec++;
    if (d !== 4) begin
      n_err++;
      $display("FAIL neg_latency got=%0d want=4", d);
    end
  endtask

  task automatic test_muldiv();
    int d;
    int want;
`ifdef CTRL_MULDIV_EN
    want = 6;
`else
    want = 3;
`endif
    start();
    drive(instr(5'b01110, 4'd7, 4'd8, 4'd9), 0, 1'b1);
    foreach (exp_q[k]) begin
      n_vec++;
      if (got_q[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL mul cyc%0d got=%h want=%h",
                 k, got_q[k], exp_q[k]);
      end
    end
    d = -1;
    foreach (got_q[k]) if (got_q[k].done && d < 0) d = k;
    n_vec++;
    if (d !== want) begin
      n_err++;
      $display("FAIL mul_latency got=%0d want=%0d",
               d, want);
    end
    drive(instr(5'b01111, 4'd2, 4'd12, 4'd14), 1, 1'b0);
    foreach (exp_q[k]) begin
      n_vec++;
      if (got_q[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL div cyc%0d got=%h want=%h",
                 k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_illegal_b2b();
    start();
    drive(instr(5'b11111, 4'd1, 4'd2, 4'd3), 0, 1'b1);
    foreach (exp_q[k]) begin
      n_vec++;
      if (got_q[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL illegal cyc%0d got=%h want=%h",
                 k, got_q[k], exp_q[k]);
      end
    end
    drive(instr(5'b00011, 4'($urandom), 4'($urandom),
                4'($urandom)), 0, 1'b0);
    foreach (exp_q[k]) begin
      n_vec++;
      if (got_q[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL b2b cyc%0d got=%h want=%h",
                 k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_random();
    bit         in_t0;
    bit         ra;
    logic [4:0] op;
    int         nw;
    in_t0 = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!in_t0) begin
        ctl.run = 1'b0;
        @(negedge Clock);
        n_vec++;
        if (observe() !== '0) begin
          n_err++;
          $display("FAIL rnd_idle it%0d got=%h want=0",
                   n, observe());
        end
        @(posedge Clock); #1;
        start();
      end
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      nw = $urandom_range(0, 3);
      ra = (n == 39) ? 1'b0 : 1'($urandom);
      drive(instr(op, 4'($urandom), 4'($urandom),
                  4'($urandom)), nw, ra);
      foreach (exp_q[k]) begin
        n_vec++;
        if (got_q[k] !== exp_q[k]) begin
          n_err++;
          $display("FAIL rnd it%0d op%0d cyc%0d got=%h want=%h",
                   n, op, k, got_q[k], exp_q[k]);
        end
      end
      in_t0 = ra;
    end
  endtask

  task automatic test_halt();
    vec_t hv;
    hv = '0;
    hv.halted = 1'b1;
    start();
    drive(instr(5'b11011, 4'd0, 4'd0, 4'd0), 1, 1'b1);
    foreach (exp_q[k]) begin
      n_vec++;
      if (got_q[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL halt cyc%0d got=%h want=%h",
                 k, got_q[k], exp_q[k]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      ctl.run = 1'b1;
      ctl.mem_ready = 1'($urandom);
      @(negedge Clock);
      n_vec++;
      if (observe() !== hv) begin
        n_err++;
        $display("FAIL halt_hold cyc%0d got=%h want=%h",
                 i, observe(), hv);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_clear_mid_wait();
    vec_t wv;
    wv = v(READ|MDRIN, 0, 0, 0, 0, 0);
    ctl.run = 1'b0;
    clear = 1'b1;
    #2;
    n_vec++;
    if (observe() !== '0) begin
      n_err++;
      $display("FAIL clear_halt got=%h want=0",
               observe());
    end
    @(posedge Clock); #1;
    clear = 1'b0;
    ctl.ir = instr(5'b00100, 4'd1, 4'd2, 4'd3);
    start();
    ctl.mem_ready = 1'b0;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    n_vec++;
    if (observe() !== wv) begin
      n_err++;
      $display("FAIL in_t1w got=%h want=%h",
               observe(), wv);
    end
    ctl.run = 1'b0;
    #2 clear = 1'b1;
    #1;
    n_vec++;
    if (observe() !== '0) begin
      n_err++;
      $display("FAIL clear_async got=%h want=0",
               observe());
    end
    @(posedge Clock); #1;
    clear = 1'b0;
    ctl.mem_ready = 1'b1;
    @(negedge Clock);
    n_vec++;
    if (observe() !== '0) begin
      n_err++;
      $display("FAIL clear_idle got=%h want=0",
               observe());
    end
    @(posedge Clock); #1;
    start();
    drive(instr(5'b01001, 4'($urandom), 4'($urandom),
                4'($urandom)), 0, 1'b0);
    foreach (exp_q[k]) begin
      n_vec++;
      if (got_q[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL restart cyc%0d got=%h want=%h",
                 k, got_q[k], exp_q[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_and();
    test_wait();
    test_neg();
    test_muldiv();
    test_illegal_b2b();
    test_random();
    test_halt();
    test_clear_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
